// File: rtl/mcfifo_pkg.sv
// Shared helpers for the multichannel FIFO bank: width derivation and default geometry.
package mcfifo_pkg;

    localparam int unsigned DefChannels = 16;
    localparam int unsigned DefDepth    = 32;

    // Bits needed to index n items; never less than 1 so a 1-bit select always exists.
    function automatic int unsigned clogb2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mcfifo_rr_pick.sv
// Round-robin first-set-bit finder: returns the first request at or after ptr_i, wrapping at N.
module mcfifo_rr_pick
    import mcfifo_pkg::*;
#(
    parameter int unsigned N = DefChannels,
    localparam int unsigned IW = clogb2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    int unsigned cand;

    // Scan from the far end so the closest request to ptr_i is the last one written.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr_i) + (N - 1 - k);
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/multichannel_fifo_rr.sv
// Channel-addressed FIFO bank in one shared RAM, with per-channel stall timers and RR stall reporting.
// Defining MCFIFO_FLUSH_EN adds the FLUSH/FCS per-channel flush port.
module multichannel_fifo_rr
    import mcfifo_pkg::*;
#(
    parameter int unsigned Channels = 16,
    parameter int unsigned Width    = 32,
    parameter int unsigned Depth    = 32,
    parameter int unsigned TmrWidth = 6,
    parameter int unsigned TmrLimit = 63,
    localparam int unsigned CW = clogb2(Channels),
    localparam int unsigned DW = clogb2(Depth)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                TCK,
`ifdef MCFIFO_FLUSH_EN
    input  logic                FLUSH,
    input  logic [CW-1:0]       FCS,
`endif
    input  logic [CW-1:0]       WCS,
    input  logic                WR,
    input  logic [Width-1:0]    DI,
    output logic                WFULL,
    output logic                WEMPTY,
    output logic [DW:0]         WLEVEL,
    input  logic [CW-1:0]       RCS,
    input  logic                RD,
    output logic [Width-1:0]    DO,
    output logic                RFULL,
    output logic                REMPTY,
    output logic [Channels-1:0] NEMPTY,
    output logic                SKIP,
    output logic [CW-1:0]       STT
);

    typedef logic [CW-1:0]       ch_t;
    typedef logic [DW:0]         cnt_t;
    typedef logic [DW-1:0]       ptr_t;
    typedef logic [TmrWidth-1:0] tmr_t;

    localparam cnt_t CntFull = cnt_t'(Depth);
    localparam tmr_t TmrMax  = tmr_t'(TmrLimit);

    logic [Width-1:0] mem [Channels*Depth];

    ptr_t wptr_q [Channels];
    ptr_t wptr_d [Channels];
    ptr_t rptr_q [Channels];
    ptr_t rptr_d [Channels];
    cnt_t cnt_q  [Channels];
    cnt_t cnt_d  [Channels];
    tmr_t tmr_q  [Channels];
    tmr_t tmr_d  [Channels];

    logic [Channels-1:0] pend_q, pend_d, nempty_q, nempty_d, flush_vec;
    logic [Width-1:0]    do_q;
    logic                skip_q;
    ch_t                 stt_q, rr_q;
    logic                pick_valid;
    ch_t                 pick_idx;
    logic                wr_acc, rd_acc;
    logic                inc, dec;

    assign WFULL  = (cnt_q[WCS] == CntFull);
    assign WEMPTY = (cnt_q[WCS] == '0);
    assign WLEVEL = cnt_q[WCS];
    assign RFULL  = (cnt_q[RCS] == CntFull);
    assign REMPTY = (cnt_q[RCS] == '0);
    assign DO     = do_q;
    assign NEMPTY = nempty_q;
    assign SKIP   = skip_q;
    assign STT    = stt_q;

    always_comb begin
        flush_vec = '0;
`ifdef MCFIFO_FLUSH_EN
        for (int n = 0; n < Channels; n++) begin
            flush_vec[n] = FLUSH && (FCS == ch_t'(n));
        end
`endif
    end

    // A flush of the addressed channel swallows any same-cycle access to it.
    assign wr_acc = WR && !WFULL && !flush_vec[WCS];
    assign rd_acc = RD && !REMPTY && !flush_vec[RCS];

    mcfifo_rr_pick #(
        .N (Channels)
    ) u_pick (
        .req_i   (pend_q),
        .ptr_i   (rr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        pend_d   = pend_q;
        nempty_d = '0;
        inc      = 1'b0;
        dec      = 1'b0;
        for (int n = 0; n < Channels; n++) begin
            inc = wr_acc && (WCS == ch_t'(n));
            dec = rd_acc && (RCS == ch_t'(n));
            if (inc) wptr_d[n] = wptr_q[n] + 1'b1;
            if (dec) rptr_d[n] = rptr_q[n] + 1'b1;
            cnt_d[n] = cnt_q[n] + cnt_t'(inc) - cnt_t'(dec);
            if ((cnt_q[n] == '0) || dec) begin
                tmr_d[n] = '0;
            end else if (TCK && (tmr_q[n] != TmrMax)) begin
                tmr_d[n] = tmr_q[n] + 1'b1;
            end
            // Pending fires only on the transition into the limit, so a saturated timer stays quiet.
            if (dec || (pick_valid && (pick_idx == ch_t'(n)))) begin
                pend_d[n] = 1'b0;
            end else if ((tmr_d[n] == TmrMax) && (tmr_q[n] != TmrMax)) begin
                pend_d[n] = 1'b1;
            end
            if (flush_vec[n]) begin
                wptr_d[n] = '0;
                rptr_d[n] = '0;
                cnt_d[n]  = '0;
                tmr_d[n]  = '0;
                pend_d[n] = 1'b0;
            end
            nempty_d[n] = (cnt_d[n] != '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[{WCS, wptr_q[WCS]}] <= DI;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int n = 0; n < Channels; n++) begin
                wptr_q[n] <= '0;
                rptr_q[n] <= '0;
                cnt_q[n]  <= '0;
                tmr_q[n]  <= '0;
            end
            pend_q   <= '0;
            nempty_q <= '0;
            do_q     <= '0;
            skip_q   <= 1'b0;
            stt_q    <= '0;
            rr_q     <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            pend_q   <= pend_d;
            nempty_q <= nempty_d;
            skip_q   <= pick_valid;
            if (rd_acc) begin
                do_q <= mem[{RCS, rptr_q[RCS]}];
            end
            if (pick_valid) begin
                stt_q <= pick_idx;
                rr_q  <= (pick_idx == ch_t'(Channels - 1)) ? '0 : pick_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multichannel_fifo_rr.sv
// Directed bench for multichannel_fifo_rr: vector table plus hand-written multi-cycle sequences.
module tb_multichannel_fifo_rr;

    logic        clk;
    logic        reset_n;
    logic        tck;
    logic [3:0]  wcs, rcs;
    logic        wr, rd;
    logic [31:0] di;
    logic        wfull, wempty, rfull, rempty;
    logic [5:0]  wlevel;
    logic [31:0] dout;
    logic [15:0] nempty;
    logic        skip;
    logic [3:0]  stt;
`ifdef MCFIFO_FLUSH_EN
    logic        flush;
    logic [3:0]  fcs;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n_skip;

    multichannel_fifo_rr dut (
        .CLK    (clk),
        .RESET  (reset_n),
        .TCK    (tck),
`ifdef MCFIFO_FLUSH_EN
        .FLUSH  (flush),
        .FCS    (fcs),
`endif
        .WCS    (wcs),
        .WR     (wr),
        .DI     (di),
        .WFULL  (wfull),
        .WEMPTY (wempty),
        .WLEVEL (wlevel),
        .RCS    (rcs),
        .RD     (rd),
        .DO     (dout),
        .RFULL  (rfull),
        .REMPTY (rempty),
        .NEMPTY (nempty),
        .SKIP   (skip),
        .STT    (stt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [3:0]  wcs;
        logic [31:0] di;
        logic        rd;
        logic [3:0]  rcs;
        logic [5:0]  exp_wlevel;
        logic        exp_rempty;
        logic [31:0] exp_do;
        logic [15:0] exp_nempty;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] model_q [$];
    logic [31:0] exp_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (skip) n_skip++;
    endtask

    task automatic idle();
        wr  = 1'b0;
        rd  = 1'b0;
        tck = 1'b0;
    endtask

    task automatic put(input logic [3:0] ch, input logic [31:0] d);
        wr = 1'b1; wcs = ch; di = d;
        step();
        wr = 1'b0;
    endtask

    task automatic get(input logic [3:0] ch);
        rd = 1'b1; rcs = ch;
        step();
        rd = 1'b0;
    endtask

    task automatic ticks(input int n);
        tck = 1'b1;
        for (int i = 0; i < n; i++) step();
        tck = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; tck = 1'b0; wr = 1'b0; rd = 1'b0;
        wcs = '0; rcs = '0; di = '0; n_skip = 0;
`ifdef MCFIFO_FLUSH_EN
        flush = 1'b0; fcs = '0;
`endif
        step();
        step();
        reset_n = 1'b1;
        check("rst_do", dout, 0);
        check("rst_skip", skip, 0);
        check("rst_stt", stt, 0);
        check("rst_nempty", nempty, 0);
        check("rst_wempty", wempty, 1);
        check("rst_wlevel", wlevel, 0);

        // 1) fill ch3, overflow is dropped, drain in order
        for (int i = 0; i < 32; i++) put(4'd3, 32'(i));
        check("t1_wfull", wfull, 1);
        check("t1_wlevel", wlevel, 32);
        check("t1_nempty", nempty, 16'h0008);
        put(4'd3, 32'h99);
        check("t1_ovf_level", wlevel, 32);
        rcs = 4'd3;
        check("t1_rfull", rfull, 1);
        for (int i = 0; i < 32; i++) begin
            get(4'd3);
            check("t1_do", dout, 32'(i));
        end
        check("t1_rempty", rempty, 1);
        get(4'd3);
        check("t1_do_hold", dout, 31);

        // 2) table: mixed traffic on ch5/ch6
        vecs[0] = '{1'b1, 4'd5, 32'hA0, 1'b0, 4'd5, 6'd1, 1'b0, 32'd31, 16'h0020};
        vecs[1] = '{1'b1, 4'd5, 32'hA1, 1'b0, 4'd5, 6'd2, 1'b0, 32'd31, 16'h0020};
        vecs[2] = '{1'b1, 4'd6, 32'hB0, 1'b0, 4'd6, 6'd1, 1'b0, 32'd31, 16'h0060};
        vecs[3] = '{1'b1, 4'd5, 32'hA2, 1'b1, 4'd6, 6'd3, 1'b1, 32'hB0, 16'h0020};
        vecs[4] = '{1'b1, 4'd5, 32'hA3, 1'b1, 4'd5, 6'd3, 1'b0, 32'hA0, 16'h0020};
        vecs[5] = '{1'b1, 4'd5, 32'hA4, 1'b0, 4'd5, 6'd4, 1'b0, 32'hA0, 16'h0020};
        vecs[6] = '{1'b0, 4'd5, 32'hFF, 1'b1, 4'd6, 6'd4, 1'b1, 32'hA0, 16'h0020};
        for (int v = 0; v < 7; v++) begin
            wr = vecs[v].wr; wcs = vecs[v].wcs; di = vecs[v].di;
            rd = vecs[v].rd; rcs = vecs[v].rcs;
            step();
            check($sformatf("vec%0d_wlevel", v), wlevel, vecs[v].exp_wlevel);
            check($sformatf("vec%0d_rempty", v), rempty, vecs[v].exp_rempty);
            check($sformatf("vec%0d_do", v), dout, vecs[v].exp_do);
            check($sformatf("vec%0d_nempty", v), nempty, vecs[v].exp_nempty);
        end
        idle();

        // 2b) 40 simultaneous write+read on ch5 across pointer wrap
        model_q = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        wr = 1'b1; rd = 1'b1; wcs = 4'd5; rcs = 4'd5;
        for (int k = 0; k < 40; k++) begin
            di = 32'hC000 + 32'(k);
            model_q.push_back(di);
            exp_word = model_q.pop_front();
            step();
            check("t2_wr_rd_do", dout, exp_word);
            check("t2_level", wlevel, 4);
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            exp_word = model_q.pop_front();
            get(4'd5);
            check("t2_drain_do", dout, exp_word);
        end

        // 3) two stuck channels reported once each, back to back
        put(4'd1, 32'h11);
        put(4'd9, 32'h99);
        n_skip = 0;
        ticks(62);
        check("t3_no_early_skip", n_skip, 0);
        ticks(1);
        check("t3_skip_pre", skip, 0);
        step();
        check("t3_skip_a", skip, 1);
        check("t3_stt_a", stt, 1);
        step();
        check("t3_skip_b", skip, 1);
        check("t3_stt_b", stt, 9);
        step();
        check("t3_skip_end", skip, 0);
        check("t3_stt_hold", stt, 9);
        n_skip = 0;
        ticks(10);
        step();
        check("t3_no_repeat", n_skip, 0);

        // 4) read just before the limit suppresses report; timer restarts on next write
        get(4'd1);
        get(4'd9);
        put(4'd2, 32'h22);
        n_skip = 0;
        ticks(62);
        get(4'd2);
        step();
        step();
        check("t4_no_skip", n_skip, 0);
        put(4'd2, 32'h23);
        ticks(62);
        step();
        check("t4_restart_quiet", n_skip, 0);
        ticks(1);
        step();
        check("t4_skip", skip, 1);
        check("t4_stt", stt, 2);
        get(4'd2);
        check("t4_do", dout, 32'h23);

        // 5) reset mid-operation with pending channels and ch7 full
        for (int i = 0; i < 32; i++) put(4'd7, 32'h7000 + 32'(i));
        get(4'd7);
        check("t5_do_pre", dout, 32'h7000);
        put(4'd7, 32'h7020);
        wcs = 4'd7;
        check("t5_full_pre", wfull, 1);
        put(4'd10, 32'hA);
        put(4'd11, 32'hB);
        put(4'd12, 32'hC);
        ticks(63);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        wcs = 4'd7;
        check("t5_wlevel", wlevel, 0);
        check("t5_wfull", wfull, 0);
        check("t5_skip", skip, 0);
        check("t5_do", dout, 0);
        check("t5_nempty", nempty, 0);
        n_skip = 0;
        for (int i = 0; i < 4; i++) step();
        check("t5_no_skip_after", n_skip, 0);

`ifdef MCFIFO_FLUSH_EN
        // 6) flush ch4 together with a write to it; ch0 must be untouched
        for (int i = 0; i < 10; i++) put(4'd4, 32'h4000 + 32'(i));
        put(4'd0, 32'hA0);
        put(4'd0, 32'hA1);
        flush = 1'b1; fcs = 4'd4;
        put(4'd4, 32'hDEAD);
        flush = 1'b0;
        wcs = 4'd4;
        check("t6_wlevel", wlevel, 0);
        check("t6_wempty", wempty, 1);
        wcs = 4'd0;
        check("t6_ch0_level", wlevel, 2);
        get(4'd4);
        check("t6_do_hold", dout, 0);
        check("t6_rempty", rempty, 1);
        put(4'd4, 32'h55);
        get(4'd4);
        check("t6_do_new", dout, 32'h55);
        get(4'd0);
        check("t6_ch0_do", dout, 32'hA0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
